// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory interface types: word type, RAM response states and
// RAM responder sizing constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Longest supported latency; sets the width of the latency counter.
  localparam int RAM_LAT_MAX    = 15;
  // Bytes per RAM word; the low address bits below this must be zero.
  localparam int RAM_WORD_BYTES = 4;

endpackage

// File: rtl/ram_lat_counter.sv
// Latency tracker for ram_responder: holds the pending flag and the BUSY
// countdown, and flags when a new request must be captured.
module ram_lat_counter
  import cpu_types_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic busy,     // responder is reporting BUSY this cycle
  input  logic match,    // live request equals the captured one
  output logic pending,
  output logic done,     // countdown finished for the captured request
  output logic capture   // load a new request this edge
);

  localparam int CNT_W = $clog2(RAM_LAT_MAX + 1);

  logic             pending_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign pending = pending_reg;
  assign done    = pending_reg && (cnt_reg == '0);
  // A BUSY cycle that is not a continuation of the captured request starts over.
  assign capture = busy && !(pending_reg && match);

  // Pending/countdown register: clear on any non-BUSY cycle, restart on capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (!busy) begin
      pending_reg <= 1'b0;
    end else if (capture) begin
      pending_reg <= 1'b1;
      cnt_reg     <= CNT_W'(LAT - 1);
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder: single-word read/write with LAT BUSY cycles before a
// one-cycle ACCESS. Optional access counters are built when RAM_STATS_EN is
// defined (adds rd_count/wr_count outputs).
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 10
) (
  input  logic      CLK,
  input  logic      RST,
  input  word_t     ramaddr,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
`ifdef RAM_STATS_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
`endif
);

  localparam int OFF_W = $clog2(RAM_WORD_BYTES);
  localparam int DEPTH = 2 ** ADDR_W;

  word_t             mem [DEPTH];
  word_t             rd_data_reg;
  word_t             req_addr_reg;
  logic              req_wr_reg;
  logic [ADDR_W-1:0] idx;
  logic              bad_addr;
  logic              match;
  logic              pending;
  logic              done;
  logic              capture;
  logic              busy;

  assign idx      = ramaddr[ADDR_W+OFF_W-1:OFF_W];
  assign bad_addr = (ramaddr[OFF_W-1:0] != '0) || ((ramaddr >> (ADDR_W + OFF_W)) != '0);
  assign match    = (ramaddr == req_addr_reg) && (ramWEN == req_wr_reg);
  assign busy     = (ramstate == BUSY);

  ram_lat_counter #(.LAT(LAT)) u_lat (
    .CLK     (CLK),
    .RST     (RST),
    .busy    (busy),
    .match   (match),
    .pending (pending),
    .done    (done),
    .capture (capture)
  );

  // Response decode in priority order: idle, conflict, bad address, ready, wait.
  always_comb begin
    ramstate = BUSY;
    if (!ramREN && !ramWEN) begin
      ramstate = FREE;
    end else if (ramREN && ramWEN) begin
      ramstate = ERROR;
    end else if (bad_addr) begin
      ramstate = ERROR;
    end else if (pending && match && done) begin
      ramstate = ACCESS;
    end
  end

  // Read data only surfaces during a read ACCESS; zero otherwise.
  always_comb begin
    ramload = '0;
    if (ramstate == ACCESS && ramREN) begin
      ramload = rd_data_reg;
    end
  end

  // Captured request identity, used to detect address/type changes mid-count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_addr_reg <= '0;
      req_wr_reg   <= 1'b0;
    end else if (capture) begin
      req_addr_reg <= ramaddr;
      req_wr_reg   <= ramWEN;
    end
  end

  // Array port. The read is registered: the cycle before ACCESS always carries
  // the same address and is BUSY (no write), so the registered word is exactly
  // the current contents. Writes are blocked while reset is asserted.
  always_ff @(posedge CLK) begin
    if (!RST && ramstate == ACCESS && ramWEN) begin
      mem[idx] <= ramstore;
    end
    rd_data_reg <= mem[idx];
  end

`ifdef RAM_STATS_EN
  // Completed-access counters, wrapping naturally at 2**32.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (ramstate == ACCESS) begin
      if (ramREN) rd_count <= rd_count + 32'd1;
      if (ramWEN) wr_count <= wr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Directed self-checking bench for ram_responder (LAT=2, ADDR_W=10).
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LAT    = 2;
  localparam int ADDR_W = 10;

  logic      CLK = 1'b0;
  logic      RST;
  word_t     ramaddr;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
`ifdef RAM_STATS_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ramaddr  (ramaddr),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef RAM_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: drive after the rising edge, check at the falling edge.
  task automatic cyc(input logic rst, input logic ren, input logic wen,
                     input word_t addr, input word_t data,
                     input ramstate_t st, input word_t ld, input string tag);
    RST = rst; ramREN = ren; ramWEN = wen; ramaddr = addr; ramstore = data;
    @(negedge CLK);
    check_val({tag, ".state"}, 32'(ramstate), 32'(st));
    check_val({tag, ".load"}, ramload, ld);
    $display("cycle %s rst=%0b ren=%0b wen=%0b addr=%h state=%0d load=%h",
             tag, rst, ren, wen, addr, ramstate, ramload);
    @(posedge CLK);
    #1;
  endtask

  // Full request held stable: LAT BUSY cycles then one ACCESS.
  task automatic xfer(input logic ren, input logic wen, input word_t addr,
                      input word_t data, input word_t ld, input string tag);
    for (int i = 0; i < LAT; i++) cyc(1'b0, ren, wen, addr, data, BUSY, 32'h0, tag);
    cyc(1'b0, ren, wen, addr, data, ACCESS, ld, tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, tag);
  endtask

  task automatic check_stats(input int rd, input int wr, input string tag);
`ifdef RAM_STATS_EN
    check_val({tag, ".rd_count"}, rd_count, 32'(rd));
    check_val({tag, ".wr_count"}, wr_count, 32'(wr));
`else
    $display("stats %s skipped (rd=%0d wr=%0d expected)", tag, rd, wr);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
    @(posedge CLK);
    #1;

    // Reset: idle is FREE; a request under reset is BUSY and never captured.
    cyc(1'b1, 1'b0, 1'b0, 32'h0,  32'h0, FREE, 32'h0, "rst_idle");
    cyc(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, BUSY, 32'h0, "rst_req");
    check_stats(0, 0, "after_rst");

    // Write then read 0x10; a request held after ACCESS restarts.
    xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "wr10");
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd10");
    cyc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, BUSY, 32'h0, "rd10_again");
    idle("idle1");

    // Known contents for later checks.
    xfer(1'b0, 1'b1, 32'h24, 32'h24242424, 32'h0, "wr24"); idle("idle2");
    xfer(1'b0, 1'b1, 32'h30, 32'h30303030, 32'h0, "wr30"); idle("idle3");
    xfer(1'b0, 1'b1, 32'h44, 32'h44444444, 32'h0, "wr44"); idle("idle4");

    // Address switch mid-count restarts the latency.
    cyc(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, BUSY, 32'h0, "rd20");
    xfer(1'b1, 1'b0, 32'h24, 32'h0, 32'h24242424, "rd24");
    idle("idle5");

    // Abandoned write leaves memory untouched.
    cyc(1'b0, 1'b0, 1'b1, 32'h30, 32'h1, BUSY, 32'h0, "wr30_abort");
    idle("abort_free");
    xfer(1'b1, 1'b0, 32'h30, 32'h0, 32'h30303030, "rd30");
    idle("idle6");

    // Errors: conflict, misaligned, out of range; pending cleared, no writes.
    cyc(1'b0, 1'b1, 1'b0, 32'h10,   32'h0,  BUSY,  32'h0, "pend10");
    cyc(1'b0, 1'b1, 1'b1, 32'h10,   32'h0,  ERROR, 32'h0, "both_en");
    cyc(1'b0, 1'b0, 1'b1, 32'h13,   32'h66, ERROR, 32'h0, "misalign");
    cyc(1'b0, 1'b1, 1'b0, 32'h3,    32'h0,  ERROR, 32'h0, "misalign_rd");
    cyc(1'b0, 1'b0, 1'b1, 32'h1010, 32'h55, ERROR, 32'h0, "range_wr");
    cyc(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0,  ERROR, 32'h0, "range_rd");
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "rd10_post_err");
    idle("idle7");
    check_stats(4, 4, "mid");

    // Reset on the cycle before ACCESS: no ACCESS; held write takes full LAT.
    cyc(1'b0, 1'b0, 1'b1, 32'h40, 32'hABCD, BUSY, 32'h0, "wr40_c0");
    cyc(1'b1, 1'b0, 1'b1, 32'h40, 32'hABCD, BUSY, 32'h0, "wr40_rst");
    check_stats(0, 0, "rst_clears");
    xfer(1'b0, 1'b1, 32'h40, 32'hABCD, 32'h0, "wr40_restart");
    idle("idle8");
    check_stats(0, 1, "after_wr40");

    // Reset aborts a write: old contents remain.
    cyc(1'b0, 1'b0, 1'b1, 32'h44, 32'h9, BUSY, 32'h0, "wr44_c0");
    cyc(1'b1, 1'b0, 1'b1, 32'h44, 32'h9, BUSY, 32'h0, "wr44_rst");
    xfer(1'b1, 1'b0, 32'h44, 32'h0, 32'h44444444, "rd44_after_rst");
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 32'h0000ABCD, "rd40");
    idle("idle9");
    check_stats(2, 0, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- RAM-side responder for the cache-to-RAM arbitration interface.
- Accepts single-word read/write requests on ramaddr/ramREN/ramWEN/ramstore.
- Returns ramstate (FREE/BUSY/ACCESS/ERROR) and ramload after a configurable latency.
- Serves as the synthesizable memory model behind the memory controller in the single-cycle and pipelined CPU benches.

Parameters:
- LAT, 2, number of BUSY cycles before ACCESS; legal range 1..15.
- ADDR_W, 10, word-index width; array depth is 2**ADDR_W 32-bit words.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- ramaddr  in  32  byte address (word_t).
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramstore  in  32  write data.
- ramload  out  32  read data; valid only while ramstate==ACCESS for a read.
- ramstate  out  2  ramstate_t response.

Behaviour:
- Registered state:
  - pending (1)
  - req_addr (32)
  - req_wr (1)
  - cnt (4)
  - mem[2**ADDR_W] (not reset)
- Reset (RST=1 at an edge): pending=0, cnt=0, req_addr=0, req_wr=0. Memory contents are preserved.
- ramstate is combinational, evaluated in priority order:
  - !ramREN && !ramWEN -> FREE.
  - ramREN && ramWEN -> ERROR.
  - ramaddr[1:0]!=0, or ramaddr[31:ADDR_W+2]!=0 -> ERROR.
  - pending && ramaddr==req_addr && ramWEN==req_wr && cnt==0 -> ACCESS.
  - otherwise -> BUSY.
- ramload:
  - mem[ramaddr[ADDR_W+1:2]] when ramstate==ACCESS && ramREN.
  - Otherwise 0.
  - While RST=1, ramstate follows the same rules, but pending=0, so ACCESS is impossible.
- Sequential rules, applied per edge when RST=0:
  - ERROR or FREE: pending<=0. No array write.
  - BUSY with (!pending or request mismatch on addr/type): capture. pending<=1, req_addr<=ramaddr, req_wr<=ramWEN, cnt<=LAT-1.
  - BUSY with matching pending request and cnt!=0: cnt<=cnt-1.
  - ACCESS: pending<=0. If ramWEN, mem[index]<=ramstore.
- Latency: a request held stable from cycle 0 shows BUSY for cycles 0..LAT-1 and ACCESS in cycle LAT.
- Exactly one ACCESS cycle per request.
  - A request still asserted the cycle after ACCESS is a new access; it restarts with LAT BUSY cycles.
  - Write-then-read of the same address back to back is therefore two full accesses.
- Mid-operation change (address, or read<->write) before ACCESS: the old request is abandoned with no array write, and the count restarts.
- Dropping both enables mid-count: FREE next cycle, pending cleared, no side effects.
- Reset asserted mid-count: pending cleared. No write occurs even if the count would have hit ACCESS.
- Requester rule: hold addr/data/enable stable until ACCESS is sampled. The memory controller drives dwait/iwait low directly from ACCESS.

Optional Feature:
- Macro: RAM_STATS_EN.
- When defined:
  - Adds outputs rd_count (32) and wr_count (32).
  - Both reset to 0 on RST.
  - Each increments by 1 on every edge where ramstate==ACCESS with ramREN or ramWEN respectively.
  - Both wrap at 2**32-1 -> 0.
- When undefined: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- ramstate_t (FREE, BUSY, ACCESS, ERROR) and word_t come from cpu_types_pkg.
- Add to that package:
  - RAM_LAT_MAX=15
  - RAM_WORD_BYTES=4
- Optional sub-module: ram_lat_counter, the cnt/pending/capture logic with a match input and done output. The array and decode stay in ram_responder.

Test Plan:
- LAT=2, ramWEN=1, addr 0x10, store 0xDEADBEEF held -> BUSY, BUSY, ACCESS on cycle 2. Then read 0x10 held -> BUSY, BUSY, ACCESS with ramload=0xDEADBEEF; ramload=0 during BUSY.
- Read 0x20 for 1 cycle, then switch to 0x24 -> count restarts; ACCESS occurs exactly LAT cycles after the switch, with ramload=mem[9].
- Write 0x30 data 0x1 held for 1 cycle, then both enables low -> FREE. A later read of 0x30 returns the old contents (not 0x1).
- ramREN=ramWEN=1 -> ERROR. Addr 0x3 -> ERROR. Addr 0x00001000 with ADDR_W=10 -> ERROR. No array change, pending=0.
- RST=1 asserted on the cycle before a pending write would reach ACCESS -> no ACCESS, no write. After release, the same held write takes the full LAT again.
- With RAM_STATS_EN: 3 reads + 2 writes completed -> rd_count=3, wr_count=2. After RST, both are 0.
